// File: rtl/bka_pkg.sv
// Shared types and defaults for the shared Brent-Kung adder arbiter.
package bka_pkg;

   localparam int BKA_WIDTH = 17;
   localparam int BKA_NREQ  = 4;
   localparam int BKA_IDW   = $clog2(BKA_NREQ);

   // Operand record held in the S1 pipeline stage.
   typedef struct packed {
      logic [BKA_WIDTH-1:0] a;
      logic [BKA_WIDTH-1:0] b;
      logic                 cin;
      logic [BKA_IDW-1:0]   id;
   } op_t;

   // Result record held in the S2 pipeline stage.
   typedef struct packed {
      logic [BKA_WIDTH-1:0] sum;
      logic                 cout;
      logic [BKA_IDW-1:0]   id;
   } res_t;

endpackage : bka_pkg

// File: rtl/bka.sv
// Brent-Kung parallel-prefix adder: sum = A + B + cin, carry out of the MSB.
// Purely combinational; the carry-in is folded into the bit-0 generate so the
// prefix tree directly yields the carry into every bit position.
module bka #(
   parameter int WIDTH = 17
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Largest span used by the down-sweep.
   localparam int TOP_D = (WIDTH > 1) ? (1 << ($clog2(WIDTH) - 1)) : 1;

   logic [WIDTH-1:0] p_s;
   logic [WIDTH-1:0] gp_s;

   assign p_s = A ^ B;

   // Prefix tree: up-sweep builds power-of-two group carries, down-sweep fills the rest.
   always_comb begin : prefix_tree
      logic [WIDTH-1:0] g_v;
      logic [WIDTH-1:0] pp_v;
      g_v    = A & B;
      pp_v   = p_s;
      g_v[0] = g_v[0] | (p_s[0] & cin);
      for (int d = 1; d < WIDTH; d = d * 2) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (((i + 1) % (2 * d)) == 0) begin
               g_v[i]  = g_v[i] | (pp_v[i] & g_v[i - d]);
               pp_v[i] = pp_v[i] & pp_v[i - d];
            end else begin
               g_v[i]  = g_v[i];
            end
         end
      end
      for (int d = TOP_D; d >= 1; d = d / 2) begin
         for (int i = 0; i < WIDTH; i++) begin
            if ((((i + 1) % (2 * d)) == d) && ((i + 1) > d)) begin
               g_v[i]  = g_v[i] | (pp_v[i] & g_v[i - d]);
               pp_v[i] = pp_v[i] & pp_v[i - d];
            end else begin
               g_v[i]  = g_v[i];
            end
         end
      end
      gp_s = g_v;
   end

   generate
      if (WIDTH > 1) begin : g_multi
         assign sum = p_s ^ {gp_s[WIDTH-2:0], cin};
      end else begin : g_single
         assign sum = p_s ^ cin;
      end
   endgenerate

   assign cout = gp_s[WIDTH-1];

endmodule : bka

// File: rtl/bka_share_arb.sv
// Round-robin arbiter plus two-stage pipeline sharing one Brent-Kung adder
// among NREQ requesters. S1 holds operands and feeds the adder; S2 registers
// the result and drives the response channel. One add per cycle when the
// response side is not stalled. The op_t/res_t records follow the package
// default widths, so WIDTH and NREQ are changed in bka_pkg.
module bka_share_arb
   import bka_pkg::*;
#(
   parameter int WIDTH = BKA_WIDTH,
   parameter int NREQ  = BKA_NREQ,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ-1:0]       req_cin,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_sum,
   output logic                  rsp_cout,
   output logic [IDW-1:0]        rsp_id
);

   logic             s1_valid_r;
   op_t              s1_op_r;
   logic             s2_valid_r;
   res_t             s2_res_r;
   logic [IDW-1:0]   ptr_r;

   logic             adv2_s;
   logic             adv1_s;
   logic [IDW-1:0]   grant_s;
   logic             found_s;
   logic             accept_s;
   logic [WIDTH-1:0] a_sel_s;
   logic [WIDTH-1:0] b_sel_s;
   logic             cin_sel_s;
   logic [WIDTH-1:0] bka_sum_s;
   logic             bka_cout_s;

   // S2 frees when empty or being read; S1 frees when empty or moving into S2.
   assign adv2_s = ~s2_valid_r | rsp_ready;
   assign adv1_s = ~s1_valid_r | adv2_s;

   // Round-robin search: first valid requester starting at ptr_r, wrapping.
   always_comb begin
      grant_s = ptr_r;
      found_s = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found_s && req_valid[(int'(ptr_r) + k) % NREQ]) begin
            grant_s = IDW'((int'(ptr_r) + k) % NREQ);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Single ready bit to the granted requester, only when S1 can take it.
   always_comb begin
      req_ready = {NREQ{1'b0}};
      if (rst_n && found_s) begin
         req_ready[grant_s] = adv1_s;
      end else begin
         req_ready = {NREQ{1'b0}};
      end
   end

   assign accept_s  = rst_n & found_s & adv1_s;
   assign a_sel_s   = req_a[int'(grant_s) * WIDTH +: WIDTH];
   assign b_sel_s   = req_b[int'(grant_s) * WIDTH +: WIDTH];
   assign cin_sel_s = req_cin[grant_s];

   // Round-robin pointer: moves past the winner on every accept, else holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_r <= {IDW{1'b0}};
      end else if (accept_s) begin
         if (grant_s == IDW'(NREQ - 1)) begin
            ptr_r <= {IDW{1'b0}};
         end else begin
            ptr_r <= grant_s + 1'b1;
         end
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // S1 operand stage: load on accept, empty when its op moves on, else hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_op_r    <= {$bits(op_t){1'b0}};
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_op_r    <= '{a: a_sel_s, b: b_sel_s, cin: cin_sel_s, id: grant_s};
      end else if (adv2_s) begin
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   bka #(
      .WIDTH (WIDTH)
   ) u_bka (
      .A    (s1_op_r.a),
      .B    (s1_op_r.b),
      .cin  (s1_op_r.cin),
      .sum  (bka_sum_s),
      .cout (bka_cout_s)
   );

   // S2 result stage: capture the adder output whenever S2 is free to advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_res_r   <= {$bits(res_t){1'b0}};
      end else if (adv2_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_res_r <= '{sum: bka_sum_s, cout: bka_cout_s, id: s1_op_r.id};
         end else begin
            s2_res_r <= s2_res_r;
         end
      end else begin
         s2_valid_r <= s2_valid_r;
      end
   end

   assign rsp_valid = s2_valid_r;
   assign rsp_sum   = s2_res_r.sum;
   assign rsp_cout  = s2_res_r.cout;
   assign rsp_id    = s2_res_r.id;

endmodule : bka_share_arb

// File: tb/tb_bka_share_arb.sv
// Scoreboard bench for bka_share_arb: a driver feeds per-requester queues,
// a logger predicts grants/accepts with an abstract round-robin model and
// pushes expected results, a monitor pops and compares on each response.
module tb_bka_share_arb;

   localparam int W  = 17;
   localparam int N  = 4;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_cin;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_sum;
   logic           rsp_cout;
   logic [IW-1:0]  rsp_id;

   always #5 clk = ~clk;

   bka_share_arb #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .rsp_id    (rsp_id)
   );

   typedef struct { longint a; longint b; longint cin; } op_s;
   typedef struct { longint sum; longint cout; longint id; longint acc_cyc; } exp_s;

   op_s  in_q[N][$];
   exp_s exp_q[$];
   bit   took[N];

   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   int  acc_total = 0;
   int  m_ptr   = 0;
   int  m_occ   = 0;
   bit  rst_req = 1'b1;
   bit  force_all = 1'b1;
   bit  offer_rand = 1'b0;
   bit  rsp_rand = 1'b0;
   bit  rsp_val = 1'b1;
   bit  chk_lat = 1'b0;
   bit  rst_prev = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer addition, reduced modulo 2^W, carry is the quotient.
   function automatic exp_s model(input op_s o, input int id, input int c);
      exp_s   e;
      longint t;
      t = o.a + o.b + o.cin;
      e.sum = t % (longint'(1) << W);
      e.cout = t / (longint'(1) << W);
      e.id = id;
      e.acc_cyc = c;
      return e;
   endfunction

   function automatic op_s mk_op(input longint a, input longint b, input longint c);
      op_s o;
      o.a = a; o.b = b; o.cin = c;
      return o;
   endfunction

   function automatic longint rnd_operand();
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) return (longint'(1) << W) - 1;
      else if (sel == 1) return 0;
      else return longint'($urandom_range(0, (1 << W) - 1));
   endfunction

   // Driver: after each rising edge, retire accepted ops and present the next.
   always begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      rst_n = !rst_req;
      for (int i = 0; i < N; i++) begin
         if (took[i]) begin
            void'(in_q[i].pop_front());
            took[i] = 1'b0;
         end
         if (force_all) begin
            req_valid[i] = 1'b1;
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
            req_cin[i] = 1'b0;
         end else if (in_q[i].size() > 0 && (!offer_rand || $urandom_range(0, 3) != 0)) begin
            req_valid[i] = 1'b1;
            req_a[i*W +: W] = W'(in_q[i][0].a);
            req_b[i*W +: W] = W'(in_q[i][0].b);
            req_cin[i] = in_q[i][0].cin[0];
         end else begin
            req_valid[i] = 1'b0;
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
            req_cin[i] = 1'($urandom);
         end
      end
      rsp_ready = rsp_rand ? 1'($urandom) : rsp_val;
   end

   // Logger: predict the grant vector, record accepts and expected results.
   always @(negedge clk) begin
      int     g;
      logic [N-1:0] exp_rdy;
      if (rst_prev) chk("rsp_valid_after_reset", longint'(rsp_valid), 0);
      if (!rst_n) begin
         chk("ready_in_reset", longint'(req_ready), 0);
         m_ptr = 0;
         m_occ = 0;
         exp_q.delete();
         for (int i = 0; i < N; i++) took[i] = 1'b0;
         rst_prev = 1'b1;
      end else begin
         rst_prev = 1'b0;
         g = -1;
         for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
         exp_rdy = '0;
         if (g >= 0 && (m_occ < 2 || rsp_ready)) exp_rdy[g] = 1'b1;
         chk("grant", longint'(req_ready), longint'(exp_rdy));
         if (exp_rdy != '0) begin
            if (in_q[g].size() > 0) begin
               exp_q.push_back(model(in_q[g][0], g, cyc));
               took[g] = 1'b1;
            end
            m_ptr = (g + 1) % N;
            m_occ++;
            acc_total++;
         end
         if (rsp_valid && rsp_ready) m_occ--;
      end
   end

   // Monitor: compare each delivered response and check stall stability.
   always @(negedge clk) begin
      static bit           stall_prev = 1'b0;
      static logic [W+IW:0] held = '0;
      exp_s e;
      if (rst_n) begin
         if (stall_prev) begin
            chk("stall_valid", longint'(rsp_valid), 1);
            chk("stall_hold", longint'({rsp_sum, rsp_cout, rsp_id}), longint'(held));
         end
         if (rsp_valid) chk("rsp_no_x", longint'($isunknown({rsp_sum, rsp_cout, rsp_id})), 0);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", longint'(rsp_id), -1);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id", longint'(rsp_id), e.id);
               chk("rsp_sum", longint'(rsp_sum), e.sum);
               chk("rsp_cout", longint'(rsp_cout), e.cout);
               if (chk_lat) chk("latency", longint'(cyc) - e.acc_cyc, 2);
            end
         end
         stall_prev = rsp_valid && !rsp_ready;
         held = {rsp_sum, rsp_cout, rsp_id};
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic wait_idle(input string name, input int bound);
      bit done;
      done = 1'b0;
      for (int t = 0; t < bound && !done; t++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && (m_occ == 0);
         for (int i = 0; i < N; i++) if (in_q[i].size() != 0) done = 1'b0;
      end
      chk(name, longint'(done), 1);
   endtask

   function automatic int queued_total();
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += in_q[i].size();
      return s;
   endfunction

   initial begin
      int base;
      int pushed;
      int guard;
      int r;
      rst_n = 1'b0;
      req_valid = '1;
      req_a = '0;
      req_b = '0;
      req_cin = '0;
      rsp_ready = 1'b1;

      // 1: reset with all requesters valid, then a single op on req0
      repeat (2) @(negedge clk);
      rst_req = 1'b0;
      force_all = 1'b0;
      chk_lat = 1'b1;
      in_q[0].push_back(mk_op(64'h5, 64'h3, 1));
      wait_idle("idle_t1", 50);

      // 2: carry-out corner cases on req2
      @(negedge clk);
      in_q[2].push_back(mk_op(64'h1FFFF, 64'h1, 0));
      in_q[2].push_back(mk_op(64'h1FFFF, 64'h1FFFF, 1));
      wait_idle("idle_t2", 50);

      // 3: all four valid, no backpressure: 0,1,2,3,0,1,2,3 with no bubbles
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         in_q[i].push_back(mk_op(rnd_operand(), rnd_operand(), $urandom_range(0, 1)));
         in_q[i].push_back(mk_op(rnd_operand(), rnd_operand(), $urandom_range(0, 1)));
      end
      wait_idle("idle_t3", 50);
      chk_lat = 1'b0;

      // 4: backpressure for 6 cycles: exactly two accepts, outputs hold
      @(negedge clk);
      rsp_val = 1'b0;
      base = acc_total;
      for (int i = 0; i < N; i++) begin
         in_q[i].push_back(mk_op(rnd_operand(), rnd_operand(), $urandom_range(0, 1)));
         in_q[i].push_back(mk_op(rnd_operand(), rnd_operand(), $urandom_range(0, 1)));
      end
      repeat (7) @(negedge clk);
      chk("stall_accepts", acc_total - base, 2);
      rsp_val = 1'b1;
      wait_idle("idle_t4", 100);

      // 5: both stages full, then a one-cycle reset
      @(negedge clk);
      rsp_val = 1'b0;
      for (int i = 0; i < N; i++) begin
         in_q[i].push_back(mk_op(rnd_operand(), rnd_operand(), $urandom_range(0, 1)));
         in_q[i].push_back(mk_op(rnd_operand(), rnd_operand(), $urandom_range(0, 1)));
      end
      repeat (4) @(negedge clk);
      rst_req = 1'b1;
      @(negedge clk);
      rst_req = 1'b0;
      @(negedge clk);
      rsp_val = 1'b1;
      wait_idle("idle_t5", 100);

      // 6: random traffic with random backpressure
      offer_rand = 1'b1;
      rsp_rand = 1'b1;
      pushed = 0;
      guard = 0;
      while (pushed < 5000 && guard < 60000) begin
         @(negedge clk);
         guard++;
         if (queued_total() < 12) begin
            r = $urandom_range(0, N - 1);
            in_q[r].push_back(mk_op(rnd_operand(), rnd_operand(), $urandom_range(0, 1)));
            pushed++;
         end
      end
      chk("random_issue_budget", pushed, 5000);
      offer_rand = 1'b0;
      rsp_rand = 1'b0;
      rsp_val = 1'b1;
      wait_idle("idle_t6", 500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule : tb_bka_share_arb

// File: doc/bka_share_arb.md
Name: bka_share_arb

Overview:
Round-robin arbiter and 2-stage pipeline that shares one Brent-Kung adder (bka) among NREQ requesters in the systolic fabric.
Each requester offers operands A, B and cin over a valid/ready handshake. The block returns sum, cout and the requester id on a single response channel that supports backpressure.
Throughput is one add per cycle when the response side is not stalled.

Parameters:
WIDTH, 17, operand/sum width in bits, passed to the bka instance.
NREQ, 4, number of requesters (>=2).
IDW, $clog2(NREQ), width of the requester id.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
req_valid  in  NREQ  per-requester request valid.
req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
req_b  in  NREQ*WIDTH  operand B, same packing as req_a.
req_cin  in  NREQ  carry-in per requester.
rsp_valid  out  1  response valid.
rsp_ready  in  1  downstream accept.
rsp_sum  out  WIDTH  (A+B+cin) mod 2^WIDTH.
rsp_cout  out  1  carry out of the MSB.
rsp_id  out  IDW  index of the requester that owns this response.

Behaviour:
- Reset and clock: one clock, clk. Reset rst_n is synchronous, active-low.
- Reset values: rsp_valid=0; rsp_sum=0; rsp_cout=0; rsp_id=0; both stage valids=0; rr pointer=0.
- Reset asserted mid-operation discards all in-flight ops.
- req_ready is 0 while rst_n=0.
- Stage S1 (operand register): holds a, b, cin and id. The bka is driven combinationally from S1.
- Stage S2 (result register): drives the rsp_* outputs.
- adv2 = !S2.valid | rsp_ready.
- adv1 = !S1.valid | adv2.
- S1 to S2 transfer happens when S1.valid & adv2.
- Arbitration:
  - grant = first i with req_valid[i]=1, searching from ptr and wrapping NREQ-1 -> 0.
  - req_ready[grant] = adv1; all other req_ready bits = 0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept = req_valid[g] & req_ready[g]. On accept:
  - S1 loads {a, b, cin, id=g}.
  - ptr <= (g+1) mod NREQ.
- ptr is unchanged when no accept occurs.
- Latency: accept at edge N gives rsp_valid=1 after edge N+1 (one cycle in S1, then registered into S2). This holds with no stall.
- Stall: while rsp_valid=1 and rsp_ready=0, rsp_* outputs hold stable.
  - S1 holds.
  - Once S1 is full, all req_ready are 0.
  - No loss, duplication or reordering.
- Simultaneous accept into S1 and S1 to S2 transfer in the same cycle is legal and is required for full throughput.
- Arithmetic: unsigned modular add. Signed users sign-extend the operands themselves. The result is bit-exact with a+b+cin truncated to WIDTH bits, with the carry in rsp_cout.
- No request pending: S1.valid clears once S1 drains; ptr holds.

Decomposition:
- Package bka_pkg:
  - default WIDTH and NREQ localparams;
  - IDW derivation;
  - struct typedef op_t {a, b, cin, id};
  - struct typedef res_t {sum, cout, id}.
- Sub-module: one instance of the existing bka #(WIDTH) (A, B, cin, sum, cout). The round-robin grant logic stays inline.

Test Plan:
1. rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0. After release, req0 a=0x00005 b=0x00003 cin=1 -> sum=0x00009, cout=0, id=0, rsp_valid one edge after accept.
2. req2 a=0x1FFFF b=0x00001 cin=0 -> sum=0x00000, cout=1, id=2. Then a=0x1FFFF b=0x1FFFF cin=1 -> sum=0x1FFFF, cout=1.
3. All 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_id in the same order with no bubbles.
4. All valid, rsp_ready=0 for 6 cycles -> exactly 2 accepts, then req_ready=0 and rsp_* stable. rsp_ready=1 -> in-order drain, no duplicate or lost ids.
5. S1 and S2 both full, then rst_n=0 for 1 cycle -> rsp_valid=0 next cycle; first post-reset grant goes to req0 when all valid.
6. 5000 random ops on random requesters with random rsp_ready -> each response equals the model (a+b+cin) truncated plus cout, per-requester order preserved, zero X on rsp_*.
